// File: rtl/eeprom_spi_responder.sv
// SPI mode-0 EEPROM responder (25xx command subset) standing in for the config EEPROM.
// Serial pins are oversampled on clk_dot4x; a committed write holds busy for WRITE_CYCLES clocks.
module eeprom_spi_responder #(
    parameter int         ADDR_BITS    = 8,
    parameter int         PAGE_BYTES   = 16,
    parameter int         WRITE_CYCLES = 1024,
    parameter logic [7:0] MEM_INIT     = 8'hFF
) (
    input  logic clk_dot4x,
    input  logic rst_n,
    input  logic spi_s,
    input  logic spi_c,
    input  logic spi_d,
    output logic spi_q,
    output logic spi_q_oe,
    output logic wel,
    output logic busy
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int PB    = $clog2(PAGE_BYTES);
    localparam int TW    = $clog2(WRITE_CYCLES) + 1;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    typedef enum logic [3:0] {
        IDLE, CMD, ARMED, ADDR_HI, ADDR_LO, READ_DATA, WRITE_DATA, STATUS, IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [1:0] s_sync, c_sync, d_sync;
    logic       s_prev, c_prev;
    logic       s_high, s_rise, s_fall, c_rise, c_fall, d_bit;

    logic [6:0]           shift_reg;
    logic [2:0]           bit_cnt;
    logic [7:0]           rx_byte, out_byte, status_byte;
    logic                 byte_done, mem_wr;
    logic [ADDR_BITS-1:0] addr, addr_shift, addr_inc, addr_page_inc;
    logic                 cmd_read, arm_set, wrote;
    logic [TW-1:0]        timer;

    // Stored XORed with MEM_INIT so that all-zero power-up storage reads back as MEM_INIT.
    logic [7:0] mem [DEPTH];

    assign s_high = s_sync[1];
    assign s_rise = s_sync[1] & ~s_prev;
    assign s_fall = ~s_sync[1] & s_prev;
    assign c_rise = c_sync[1] & ~c_prev;
    assign c_fall = ~c_sync[1] & c_prev;
    assign d_bit  = d_sync[1];

    assign rx_byte       = {shift_reg, d_bit};
    assign byte_done     = c_rise && (bit_cnt == 3'd7);
    assign status_byte   = {6'b0, wel, busy};
    assign addr_shift    = {addr[ADDR_BITS-2:0], d_bit};
    assign addr_inc      = addr + ADDR_BITS'(1);
    assign addr_page_inc = {addr[ADDR_BITS-1:PB], addr[PB-1:0] + PB'(1)};
    assign mem_wr        = !s_high && (state_q == WRITE_DATA) && byte_done;
    assign spi_q_oe      = (state_q == READ_DATA) || (state_q == STATUS);

    always_comb begin
        state_d = state_q;
        if (s_high) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (s_fall) state_d = CMD;
                CMD: begin
                    if (byte_done) begin
                        if (busy && rx_byte != OP_RDSR) begin
                            state_d = IGNORE;
                        end else begin
                            case (rx_byte)
                                OP_READ:          state_d = ADDR_HI;
                                OP_WRITE:         state_d = wel ? ADDR_HI : IGNORE;
                                OP_WREN, OP_WRDI: state_d = ARMED;
                                OP_RDSR:          state_d = STATUS;
                                default:          state_d = IGNORE;
                            endcase
                        end
                    end
                end
                ARMED:   if (c_rise) state_d = IGNORE;
                ADDR_HI: if (byte_done) state_d = ADDR_LO;
                ADDR_LO: if (byte_done) state_d = cmd_read ? READ_DATA : WRITE_DATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_sync    <= 2'b11;
            s_prev    <= 1'b1;
            c_sync    <= 2'b00;
            c_prev    <= 1'b0;
            d_sync    <= 2'b00;
            shift_reg <= '0;
            bit_cnt   <= '0;
            addr      <= '0;
            out_byte  <= '0;
            spi_q     <= 1'b1;
            wel       <= 1'b0;
            busy      <= 1'b0;
            timer     <= '0;
            cmd_read  <= 1'b0;
            arm_set   <= 1'b0;
            wrote     <= 1'b0;
        end else begin
            state_q <= state_d;
            s_sync  <= {s_sync[0], spi_s};
            c_sync  <= {c_sync[0], spi_c};
            d_sync  <= {d_sync[0], spi_d};
            s_prev  <= s_sync[1];
            c_prev  <= c_sync[1];

            if (busy) begin
                if (timer == '0) busy <= 1'b0;
                else             timer <= timer - TW'(1);
            end

            if (s_high) begin
                bit_cnt <= '0;
                if (s_rise && state_q == ARMED) wel <= arm_set;
                if (s_rise && state_q == WRITE_DATA && wrote) begin
                    wel   <= 1'b0;
                    busy  <= 1'b1;
                    timer <= TW'(WRITE_CYCLES - 1);
                end
            end else begin
                if (c_rise) begin
                    shift_reg <= rx_byte[6:0];
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (state_q == ADDR_HI || state_q == ADDR_LO) addr <= addr_shift;
                end
                if (byte_done) begin
                    case (state_q)
                        CMD: begin
                            cmd_read <= (rx_byte == OP_READ);
                            arm_set  <= (rx_byte == OP_WREN);
                            wrote    <= 1'b0;
                            out_byte <= status_byte;
                        end
                        ADDR_LO:    out_byte <= mem[addr_shift] ^ MEM_INIT;
                        WRITE_DATA: begin
                            addr  <= addr_page_inc;
                            wrote <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                // The rise counter doubles as the output bit index: it has already wrapped to 0 before the first fall.
                if (c_fall && spi_q_oe) begin
                    spi_q <= out_byte[3'd7 - bit_cnt];
                    if (bit_cnt == 3'd7) begin
                        if (state_q == READ_DATA) begin
                            addr     <= addr_inc;
                            out_byte <= mem[addr_inc] ^ MEM_INIT;
                        end else begin
                            out_byte <= status_byte;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (mem_wr) mem[addr] <= rx_byte ^ MEM_INIT;
    end

endmodule

// File: tb/tb_eeprom_spi_responder.sv
// Bench for eeprom_spi_responder: SPI master tasks, an array model of the EEPROM,
// and a monitor that pops expected read bytes from a scoreboard queue.
module tb_eeprom_spi_responder;
    localparam int HALF = 6;
    localparam int WCYC = 1024;

    logic clk_dot4x = 1'b0;
    logic rst_n     = 1'b0;
    logic spi_s     = 1'b1;
    logic spi_c     = 1'b0;
    logic spi_d     = 1'b0;
    logic spi_q, spi_q_oe, wel, busy;

    eeprom_spi_responder #(
        .ADDR_BITS(8), .PAGE_BYTES(16), .WRITE_CYCLES(WCYC), .MEM_INIT(8'hFF)
    ) dut (
        .clk_dot4x(clk_dot4x), .rst_n(rst_n), .spi_s(spi_s), .spi_c(spi_c), .spi_d(spi_d),
        .spi_q(spi_q), .spi_q_oe(spi_q_oe), .wel(wel), .busy(busy)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] m_mem [256];
    logic       m_wel  = 1'b0;
    logic       m_busy = 1'b0;
    logic [7:0] tx_data [8];

    task automatic ticks(input int n);
        repeat (n) @(negedge clk_dot4x);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_d = v[i];
            ticks(HALF);
            spi_c = 1'b1;
            ticks(HALF);
            spi_c = 1'b0;
        end
    endtask

    // One chip-select frame; the model predicts read-back bytes up front and applies side effects after.
    task automatic applyStimulus(input logic [7:0] op, input logic [15:0] a, input int n_data, input int partial_bits);
        logic [7:0] wa;
        logic [7:0] idx;
        spi_s = 1'b0;
        ticks(4);
        send_bits(op, 8);
        if (op == 8'h02 || op == 8'h03) begin
            send_bits(a[15:8], 8);
            send_bits(a[7:0], 8);
        end
        if (op == 8'h03 && !m_busy) begin
            for (int k = 0; k < n_data; k++) begin
                idx = a[7:0] + 8'(k);
                exp_q.push_back(m_mem[idx]);
            end
        end
        if (op == 8'h05) begin
            for (int k = 0; k < n_data; k++) exp_q.push_back({6'b0, m_wel, m_busy});
        end
        for (int k = 0; k < n_data; k++) send_bits((op == 8'h02) ? tx_data[k] : 8'($urandom), 8);
        if (partial_bits > 0) send_bits(8'($urandom), partial_bits);
        ticks(HALF);
        spi_s = 1'b1;
        ticks(8);
        if (!m_busy) begin
            case (op)
                8'h02: if (m_wel) begin
                    wa = a[7:0];
                    for (int k = 0; k < n_data; k++) begin
                        m_mem[wa] = tx_data[k];
                        wa = (wa & 8'hF0) | ((wa + 8'd1) & 8'h0F);
                    end
                    if (n_data > 0) begin
                        m_wel  = 1'b0;
                        m_busy = 1'b1;
                    end
                end
                8'h06: if (n_data == 0 && partial_bits == 0) m_wel = 1'b1;
                8'h04: if (n_data == 0 && partial_bits == 0) m_wel = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic wait_idle();
        if (m_busy) begin
            for (int i = 0; i < 3000 && busy; i++) ticks(1);
            checkOutput("busyRelease", busy, 0);
            m_busy = 1'b0;
        end
    endtask

    // Serial-out monitor: assembles bytes the way a master would and checks them against the queue.
    initial begin
        int         mbits;
        logic [7:0] mbyte;
        mbits = 0;
        mbyte = '0;
        forever begin
            @(posedge spi_c or posedge spi_s or negedge rst_n);
            if (spi_s || !rst_n) begin
                mbits = 0;
            end else if (spi_q_oe) begin
                mbyte = {mbyte[6:0], spi_q};
                mbits++;
                if (mbits == 8) begin
                    mbits = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpectedByte: got %02h, expected no output", mbyte);
                    end else begin
                        checkOutput("readByte", mbyte, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Every uninterrupted busy pulse must last exactly WCYC clocks.
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk_dot4x);
            if (!rst_n) run = 0;
            else if (busy) run++;
            else if (run > 0) begin
                checkOutput("busyLength", run, WCYC);
                run = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: run did not complete, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int sel, n;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;

        ticks(5);
        checkOutput("rstSpiQ", spi_q, 1);
        checkOutput("rstOe", spi_q_oe, 0);
        checkOutput("rstWel", wel, 0);
        checkOutput("rstBusy", busy, 0);
        rst_n = 1'b1;
        ticks(5);

        applyStimulus(8'h05, 16'h0, 1, 0);
        checkOutput("oeAfterCs", spi_q_oe, 0);

        applyStimulus(8'h06, 16'h0, 0, 0);
        checkOutput("welSet", wel, m_wel);
        applyStimulus(8'h05, 16'h0, 1, 0);
        applyStimulus(8'h04, 16'h0, 0, 0);
        checkOutput("welClear", wel, m_wel);
        applyStimulus(8'h05, 16'h0, 1, 0);
        applyStimulus(8'h06, 16'h0, 0, 1);
        checkOutput("welExtraClk", wel, m_wel);
        applyStimulus(8'h05, 16'h0, 1, 0);

        tx_data[0] = 8'hA5;
        applyStimulus(8'h02, 16'h0010, 1, 0);
        checkOutput("noWrenBusy", busy, 0);
        applyStimulus(8'h03, 16'h0010, 1, 0);

        applyStimulus(8'h06, 16'h0, 0, 0);
        tx_data[0] = 8'h11;
        tx_data[1] = 8'h22;
        tx_data[2] = 8'h33;
        applyStimulus(8'h02, 16'h000E, 3, 0);
        checkOutput("pageBusy", busy, m_busy);
        checkOutput("pageWel", wel, m_wel);
        applyStimulus(8'h05, 16'h0, 1, 0);
        applyStimulus(8'h03, 16'h000E, 2, 0);
        checkOutput("busyReadOe", spi_q_oe, 0);
        wait_idle();
        applyStimulus(8'h03, 16'h000E, 2, 0);
        applyStimulus(8'h03, 16'h0000, 1, 0);

        applyStimulus(8'h03, 16'h00FF, 2, 0);

        applyStimulus(8'h06, 16'h0, 0, 0);
        applyStimulus(8'h02, 16'h0020, 0, 5);
        checkOutput("partialBusy", busy, m_busy);
        checkOutput("partialWel", wel, m_wel);
        applyStimulus(8'h03, 16'h0020, 1, 0);

        tx_data[0] = 8'h5C;
        applyStimulus(8'h06, 16'h0, 0, 0);
        applyStimulus(8'h02, 16'h0030, 1, 0);
        for (int i = 0; i < 50 && !busy; i++) ticks(1);
        ticks(10);
        rst_n = 1'b0;
        #1;
        checkOutput("midBusyRstBusy", busy, 0);
        checkOutput("midBusyRstWel", wel, 0);
        checkOutput("midBusyRstOe", spi_q_oe, 0);
        m_wel  = 1'b0;
        m_busy = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        ticks(5);
        applyStimulus(8'h03, 16'h0030, 1, 0);

        for (int it = 0; it < 18; it++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: applyStimulus(8'h06, 16'h0, 0, 0);
                1: applyStimulus(8'h04, 16'h0, 0, 0);
                2: begin
                    if ($urandom_range(0, 3) != 0) applyStimulus(8'h06, 16'h0, 0, 0);
                    n = $urandom_range(1, 5);
                    for (int k = 0; k < 8; k++) tx_data[k] = 8'($urandom);
                    applyStimulus(8'h02, 16'($urandom), n, ($urandom_range(0, 1) != 0) ? $urandom_range(1, 7) : 0);
                end
                3: applyStimulus(8'h03, 16'($urandom), $urandom_range(1, 3), 0);
                4: applyStimulus(8'h05, 16'h0, $urandom_range(1, 2), 0);
                default: applyStimulus(8'hA0 | 8'($urandom_range(0, 15)), 16'h0, 1, 0);
            endcase
            checkOutput("randWel", wel, m_wel);
            checkOutput("randBusy", busy, m_busy);
            wait_idle();
        end

        ticks(20);
        checkOutput("scoreboardDrained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
